// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared widths and types for the DDS phase-to-amplitude path
package dds_pkg;
  localparam int PHASE_W = 10;
  localparam int AMP_W   = 8;
  localparam int QTR_W   = PHASE_W - 2;

  typedef logic [PHASE_W-1:0]      phase_t;
  typedef logic signed [AMP_W-1:0] sample_t;

  localparam logic [AMP_W-1:0] DAC_MID = 8'h80;
endpackage

// File: rtl/sine_qtr_rom.sv
// rtl/sine_qtr_rom.sv - 256 x 7 quarter-wave sine ROM with registered read
module sine_qtr_rom
  import dds_pkg::*;
(
  input  logic             clk,
  input  logic [QTR_W-1:0] addr,
  output logic [AMP_W-2:0] data
);
  localparam real PI      = 3.141592653589793;
  localparam real FULL    = real'(4 << QTR_W);
  localparam real AMP_MAX = real'((1 << (AMP_W - 1)) - 1);

  logic [AMP_W-2:0] rom [1 << QTR_W];

  // Table is folded at elaboration from the same half-sample-offset formula as sine_qtr.hex.
  for (genvar i = 0; i < (1 << QTR_W); i++) begin : g_rom
    localparam int VAL = $rtoi(AMP_MAX * $sin(PI * (2.0 * i + 1.0) / FULL) + 0.5);
    assign rom[i] = VAL[AMP_W-2:0];
  end

  always_ff @(posedge clk) begin
    data <= rom[addr];
  end
endmodule

// File: rtl/dds_sine_lut.sv
// rtl/dds_sine_lut.sv - 3-stage phase-to-sine converter with quadrant folding
module dds_sine_lut #(
  parameter int    PHASE_W  = 10,
  parameter int    AMP_W    = 8,
  parameter string ROM_FILE = "sine_qtr.hex"
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] phase,
  input  logic               phase_valid,
  output logic [AMP_W-1:0]   sample,
  output logic [AMP_W-1:0]   dac_code,
  output logic               sample_valid
);
  import dds_pkg::*;

  if (PHASE_W != 10 || AMP_W != 8 || ROM_FILE == "") begin : g_param_check
    $error("dds_sine_lut: only PHASE_W=10, AMP_W=8 with a ROM image are supported");
  end

  logic [QTR_W-1:0] addr1;
  logic             neg1, v1;
  logic [AMP_W-2:0] mag2;
  logic             neg2, v2;
  sample_t          mag_ext, signed_mag;

  // Odd quadrants walk the quarter wave backwards; bitwise inversion mirrors the index.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr1 <= '0;
      neg1  <= 1'b0;
      v1    <= 1'b0;
    end else begin
      addr1 <= phase[PHASE_W-2] ? ~phase[QTR_W-1:0] : phase[QTR_W-1:0];
      neg1  <= phase[PHASE_W-1];
      v1    <= phase_valid;
    end
  end

  sine_qtr_rom u_rom (
    .clk  (clk),
    .addr (addr1),
    .data (mag2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      neg2 <= 1'b0;
      v2   <= 1'b0;
    end else begin
      neg2 <= neg1;
      v2   <= v1;
    end
  end

  always_comb begin
    mag_ext    = sample_t'({1'b0, mag2});
    signed_mag = neg2 ? -mag_ext : mag_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample       <= '0;
      dac_code     <= DAC_MID;
      sample_valid <= 1'b0;
    end else begin
      sample       <= signed_mag;
      dac_code     <= {~signed_mag[AMP_W-1], signed_mag[AMP_W-2:0]};
      sample_valid <= v2;
    end
  end
endmodule

// File: tb/tb_dds_sine_lut.sv
// tb/tb_dds_sine_lut.sv - self-checking bench for dds_sine_lut
module tb_dds_sine_lut;
  localparam real PI    = 3.141592653589793;
  localparam int  DEPTH = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] phase = '0;
  logic       phase_valid = 1'b0;
  logic [7:0] sample, dac_code;
  logic       sample_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int hist_phase [DEPTH];
  bit hist_pv    [DEPTH];
  bit hist_rst   [DEPTH];
  int obs_s      [DEPTH];
  int obs_d      [DEPTH];
  bit obs_v      [DEPTH];

  dds_sine_lut dut (
    .clk          (clk),
    .rst          (rst),
    .phase        (phase),
    .phase_valid  (phase_valid),
    .sample       (sample),
    .dac_code     (dac_code),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  // Ideal sine at the half-sample offset over the full circle, rounded half away from zero.
  function automatic int golden(int p);
    real x;
    x = 127.0 * $sin(2.0 * PI * (real'(p) + 0.5) / 1024.0);
    if (x >= 0.0) return $rtoi($floor(x + 0.5));
    return -$rtoi($floor(-x + 0.5));
  endfunction

  function automatic bit exp_v(int n);
    if (n < 2) return 1'b0;
    return !hist_rst[n] && !hist_rst[n-1] && !hist_rst[n-2] && hist_pv[n-2];
  endfunction

  function automatic bit data_known(int n);
    if (n < 2) return 1'b0;
    return !hist_rst[n] && !hist_rst[n-1] && !hist_rst[n-2];
  endfunction

  task automatic tick();
    @(posedge clk);
    hist_phase[cyc] = int'(phase);
    hist_pv[cyc]    = phase_valid;
    hist_rst[cyc]   = rst;
    #1;
    obs_s[cyc] = int'($signed(sample));
    obs_d[cyc] = int'(dac_code);
    obs_v[cyc] = sample_valid;
    cyc++;
  endtask

  task automatic test_reset();
    int base;
    base = cyc;
    rst = 1'b1; phase_valid = 1'b0; phase = '0;
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    for (int n = base; n < cyc; n++) begin
      n_checks += 3;
      if (obs_s[n] !== 0) begin n_fail++; $display("FAIL reset_sample cyc=%0d got=%0d exp=0", n, obs_s[n]); end
      if (obs_d[n] !== 128) begin n_fail++; $display("FAIL reset_dac cyc=%0d got=%0d exp=128", n, obs_d[n]); end
      if (obs_v[n] !== 1'b0) begin n_fail++; $display("FAIL reset_valid cyc=%0d got=%0b exp=0", n, obs_v[n]); end
    end
  endtask

  task automatic test_quadrants();
    int ph [8]    = '{0, 255, 256, 511, 512, 767, 768, 1023};
    int exp_s [8] = '{0, 127, 127, 0, 0, -127, -127, 0};
    int exp_d [8] = '{128, 255, 255, 128, 128, 1, 1, 128};
    int base;
    base = cyc;
    for (int k = 0; k < 8; k++) begin
      phase = 10'(ph[k]); phase_valid = 1'b1; tick();
    end
    phase_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    for (int k = 0; k < 8; k++) begin
      n_checks += 3;
      if (obs_s[base+k+2] !== exp_s[k]) begin n_fail++; $display("FAIL quad_sample ph=%0d got=%0d exp=%0d", ph[k], obs_s[base+k+2], exp_s[k]); end
      if (obs_d[base+k+2] !== exp_d[k]) begin n_fail++; $display("FAIL quad_dac ph=%0d got=%0d exp=%0d", ph[k], obs_d[base+k+2], exp_d[k]); end
      if (obs_v[base+k+2] !== 1'b1) begin n_fail++; $display("FAIL quad_valid ph=%0d got=%0b exp=1", ph[k], obs_v[base+k+2]); end
    end
  endtask

  task automatic test_sweep();
    int base, mn, mx, s;
    base = cyc;
    for (int p = 0; p < 1024; p++) begin
      phase = 10'(p); phase_valid = 1'b1; tick();
    end
    phase_valid = 1'b0;
    tick(); tick();
    mn = 1000; mx = -1000;
    for (int p = 0; p < 1024; p++) begin
      s = obs_s[base+p+2];
      if (s < mn) mn = s;
      if (s > mx) mx = s;
      n_checks += 3;
      if (s !== golden(p)) begin n_fail++; $display("FAIL sweep_sample ph=%0d got=%0d exp=%0d", p, s, golden(p)); end
      if (obs_d[base+p+2] !== golden(p) + 128) begin n_fail++; $display("FAIL sweep_dac ph=%0d got=%0d exp=%0d", p, obs_d[base+p+2], golden(p) + 128); end
      if (obs_v[base+p+2] !== 1'b1) begin n_fail++; $display("FAIL sweep_valid ph=%0d got=%0b exp=1", p, obs_v[base+p+2]); end
    end
    for (int p = 0; p < 512; p++) begin
      n_checks++;
      if (obs_s[base+p+514] !== -obs_s[base+p+2]) begin
        n_fail++; $display("FAIL odd_symmetry ph=%0d got=%0d exp=%0d", p + 512, obs_s[base+p+514], -obs_s[base+p+2]);
      end
    end
    n_checks += 2;
    if (mn !== -127) begin n_fail++; $display("FAIL sweep_min got=%0d exp=-127", mn); end
    if (mx !== 127) begin n_fail++; $display("FAIL sweep_max got=%0d exp=127", mx); end
  endtask

  task automatic test_valid_pattern();
    bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int base;
    base = cyc;
    for (int k = 0; k < 5; k++) begin
      phase = 10'($urandom_range(1023)); phase_valid = pat[k]; tick();
    end
    phase_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (obs_v[base+k+2] !== pat[k]) begin n_fail++; $display("FAIL valid_pattern k=%0d got=%0b exp=%0b", k, obs_v[base+k+2], pat[k]); end
      if (pat[k]) begin
        n_checks++;
        if (obs_s[base+k+2] !== golden(hist_phase[base+k])) begin
          n_fail++; $display("FAIL valid_data k=%0d got=%0d exp=%0d", k, obs_s[base+k+2], golden(hist_phase[base+k]));
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    int base, p, r;
    base = cyc; p = 0; r = 0;
    for (int k = 0; k < 30; k++) begin
      rst = (k == 20); phase = 10'(p); phase_valid = 1'b1;
      if (k == 20) r = cyc;
      tick();
      p = (p + 37) % 1024;
    end
    rst = 1'b0; phase_valid = 1'b0;
    tick(); tick();
    for (int n = base; n < cyc; n++) begin
      n_checks++;
      if (obs_v[n] !== exp_v(n)) begin n_fail++; $display("FAIL midrst_valid cyc=%0d got=%0b exp=%0b", n, obs_v[n], exp_v(n)); end
      if (data_known(n)) begin
        n_checks++;
        if (obs_s[n] !== golden(hist_phase[n-2])) begin
          n_fail++; $display("FAIL midrst_sample cyc=%0d got=%0d exp=%0d", n, obs_s[n], golden(hist_phase[n-2]));
        end
      end
    end
    n_checks += 5;
    if (obs_v[r] !== 1'b0 || obs_s[r] !== 0) begin n_fail++; $display("FAIL midrst_flush got v=%0b s=%0d exp v=0 s=0", obs_v[r], obs_s[r]); end
    if (obs_d[r] !== 128) begin n_fail++; $display("FAIL midrst_dac got=%0d exp=128", obs_d[r]); end
    if (obs_v[r+1] !== 1'b0) begin n_fail++; $display("FAIL midrst_gap1 got=%0b exp=0", obs_v[r+1]); end
    if (obs_v[r+2] !== 1'b0) begin n_fail++; $display("FAIL midrst_gap2 got=%0b exp=0", obs_v[r+2]); end
    if (obs_v[r+3] !== 1'b1) begin n_fail++; $display("FAIL midrst_resume got=%0b exp=1", obs_v[r+3]); end
  endtask

  task automatic test_wrap();
    int ph [4] = '{800, 1000, 176, 376};
    int base, rom23, rom176;
    base = cyc;
    rom23  = $rtoi(127.0 * $sin(PI * 47.0 / 1024.0) + 0.5);
    rom176 = $rtoi(127.0 * $sin(PI * 353.0 / 1024.0) + 0.5);
    for (int k = 0; k < 4; k++) begin
      phase = 10'(ph[k]); phase_valid = 1'b1; tick();
    end
    phase_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    n_checks += 4;
    if (obs_s[base+3] !== -rom23) begin n_fail++; $display("FAIL wrap_1000 got=%0d exp=%0d", obs_s[base+3], -rom23); end
    if (obs_s[base+4] !== rom176) begin n_fail++; $display("FAIL wrap_176 got=%0d exp=%0d", obs_s[base+4], rom176); end
    if (obs_v[base+3] !== 1'b1 || obs_v[base+4] !== 1'b1) begin
      n_fail++; $display("FAIL wrap_valid got=%0b%0b exp=11", obs_v[base+3], obs_v[base+4]);
    end
    if (obs_s[base+5] !== golden(376)) begin n_fail++; $display("FAIL wrap_376 got=%0d exp=%0d", obs_s[base+5], golden(376)); end
  endtask

  task automatic test_random();
    int base;
    base = cyc;
    for (int k = 0; k < 200; k++) begin
      phase = 10'($urandom_range(1023)); phase_valid = 1'($urandom_range(1)); tick();
    end
    phase_valid = 1'b0;
    tick(); tick();
    for (int n = base; n < cyc; n++) begin
      n_checks++;
      if (obs_v[n] !== exp_v(n)) begin n_fail++; $display("FAIL rand_valid cyc=%0d got=%0b exp=%0b", n, obs_v[n], exp_v(n)); end
      if (data_known(n)) begin
        n_checks += 2;
        if (obs_s[n] !== golden(hist_phase[n-2])) begin
          n_fail++; $display("FAIL rand_sample cyc=%0d got=%0d exp=%0d", n, obs_s[n], golden(hist_phase[n-2]));
        end
        if (obs_d[n] !== golden(hist_phase[n-2]) + 128) begin
          n_fail++; $display("FAIL rand_dac cyc=%0d got=%0d exp=%0d", n, obs_d[n], golden(hist_phase[n-2]) + 128);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_quadrants();
    test_sweep();
    test_valid_pattern();
    test_reset_midstream();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
